// File: rtl/logic_reduce_pipe_pkg.sv
// macro_pkg: shared constants and elaboration-time helpers for the
// pipelined reduction gate.
//   MODE_AND / MODE_OR / MODE_XOR : reduction operator selectors
//   clog_base(width, base)        : number of tree levels (LAT), minimum 1
//   level_width(width, base, k)   : bit count entering tree level k
//   level_offset(width, base, k)  : position of level k in a flattened chain
//   identity(mode)                : pad bit that leaves the reduction unchanged
package macro_pkg;

    localparam int unsigned MODE_AND = 0;
    localparam int unsigned MODE_OR  = 1;
    localparam int unsigned MODE_XOR = 2;

    function automatic int unsigned clog_base(input int unsigned width,
                                              input int unsigned base);
        int unsigned n;
        int unsigned lat;
        n   = width;
        lat = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (n > 1) begin
                n   = (n + base - 1) / base;
                lat = lat + 1;
            end
        end
        if (lat == 0) begin
            lat = 1;
        end
        return lat;
    endfunction

    function automatic int unsigned level_width(input int unsigned width,
                                                input int unsigned base,
                                                input int unsigned level);
        int unsigned n;
        n = width;
        for (int unsigned i = 0; i < level; i++) begin
            n = (n + base - 1) / base;
        end
        return n;
    endfunction

    function automatic int unsigned level_offset(input int unsigned width,
                                                 input int unsigned base,
                                                 input int unsigned level);
        int unsigned off;
        off = 0;
        for (int unsigned j = 0; j < level; j++) begin
            off = off + level_width(width, base, j);
        end
        return off;
    endfunction

    function automatic logic identity(input int unsigned mode);
        return (mode == MODE_AND) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/logic_reduce_pipe_if.sv
// logic_reduce_pipe_if: sample/result bundle for logic_reduce_pipe.
//   CE : clock enable (0 freezes the whole pipeline)
//   VI : input sample valid
//   A  : WIDTH-bit input vector, A[0] is the legacy A0 pin
//   Z0 : registered reduced result
//   VO : registered result valid
// master drives CE/VI/A and observes Z0/VO; slave is the gate itself.
interface logic_reduce_pipe_if #(
    parameter int unsigned WIDTH = 7
);
    logic             CE;
    logic             VI;
    logic [WIDTH-1:0] A;
    logic             Z0;
    logic             VO;

    modport master (output CE, VI, A, input Z0, VO);
    modport slave  (input CE, VI, A, output Z0, VO);
endinterface

// File: rtl/logic_reduce_pipe_reduce_stage.sv
// reduce_stage: one registered level of the reduction tree.
//   clk       : rising-edge clock
//   rst       : synchronous active-high clear (wins over ce)
//   ce        : clock enable, 0 holds data and valid
//   valid_in  : valid bit travelling with data_in
//   data_in   : IN_W bits from the previous level (or the input vector)
//   valid_out : registered valid
//   data_out  : ceil(IN_W/FANIN) registered chunk reductions
// FINAL_INV inverts the reduced bits ahead of the register.
module reduce_stage
    import macro_pkg::*;
#(
    parameter int unsigned IN_W      = 7,
    parameter int unsigned FANIN     = 4,
    parameter int unsigned MODE      = MODE_AND,
    parameter bit          FINAL_INV = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ce,
    input  logic                             valid_in,
    input  logic [IN_W-1:0]                  data_in,
    output logic                             valid_out,
    output logic [(IN_W+FANIN-1)/FANIN-1:0]  data_out
);

    localparam int unsigned OUT_W  = (IN_W + FANIN - 1) / FANIN;
    localparam int unsigned PAD_W  = OUT_W * FANIN;
    localparam logic        ID_BIT = identity(MODE);

    logic [PAD_W-1:0] padded;
    logic [FANIN-1:0] chunk;
    logic [OUT_W-1:0] reduced;
    logic [OUT_W-1:0] data_next;

    always_comb begin
        padded  = {PAD_W{ID_BIT}};
        chunk   = '0;
        reduced = '0;
        // Short top chunk is filled with the operator's identity bit.
        padded[IN_W-1:0] = data_in;
        for (int unsigned o = 0; o < OUT_W; o++) begin
            chunk = padded[o*FANIN +: FANIN];
            if (MODE == MODE_AND) begin
                reduced[o] = &chunk;
            end else if (MODE == MODE_OR) begin
                reduced[o] = |chunk;
            end else begin
                reduced[o] = ^chunk;
            end
        end
        data_next = reduced ^ {OUT_W{FINAL_INV}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (ce) begin
            valid_out <= valid_in;
            data_out  <= data_next;
        end
    end

endmodule

// File: rtl/logic_reduce_pipe.sv
// logic_reduce_pipe: pipelined WIDTH-input AND/OR/XOR gate built from a tree
// of FANIN-input gates, one register per level (LAT = clog_base levels).
//   CK  : rising-edge clock
//   CD  : synchronous active-high reset, priority over CE
//   bus : slave side of logic_reduce_pipe_if (CE, VI, A in; Z0, VO out)
// INVERT=1 gives NAND/NOR/XNOR, applied ahead of the final register.
module logic_reduce_pipe
    import macro_pkg::*;
#(
    parameter int unsigned WIDTH  = 7,
    parameter int unsigned FANIN  = 4,
    parameter int unsigned MODE   = MODE_AND,
    parameter int unsigned INVERT = 0
) (
    input logic                 CK,
    input logic                 CD,
    logic_reduce_pipe_if.slave  bus
);

    localparam int unsigned LAT     = clog_base(WIDTH, FANIN);
    localparam int unsigned CHAIN_W = level_offset(WIDTH, FANIN, LAT + 1);

    if (MODE > MODE_XOR) begin : g_bad_mode
        $error("logic_reduce_pipe: MODE must be 0 (AND), 1 (OR) or 2 (XOR)");
    end
    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("logic_reduce_pipe: WIDTH must be in 2..64");
    end
    if (FANIN < 2 || FANIN > 8) begin : g_bad_fanin
        $error("logic_reduce_pipe: FANIN must be in 2..8");
    end

    // All level vectors are packed back to back: level 0 is the input
    // vector, the last bit is the final registered result.
    logic [CHAIN_W-1:0] chain;
    logic [LAT:0]       vchain;

    assign chain[WIDTH-1:0] = bus.A;
    assign vchain[0]        = bus.VI;

    for (genvar k = 0; k < LAT; k++) begin : g_level
        localparam int unsigned IN_OFF  = level_offset(WIDTH, FANIN, k);
        localparam int unsigned IN_W    = level_width(WIDTH, FANIN, k);
        localparam int unsigned OUT_OFF = level_offset(WIDTH, FANIN, k + 1);
        localparam int unsigned OUT_W   = level_width(WIDTH, FANIN, k + 1);

        reduce_stage #(
            .IN_W      (IN_W),
            .FANIN     (FANIN),
            .MODE      (MODE),
            .FINAL_INV ((k == LAT - 1) && (INVERT != 0))
        ) u_stage (
            .clk       (CK),
            .rst       (CD),
            .ce        (bus.CE),
            .valid_in  (vchain[k]),
            .data_in   (chain[IN_OFF +: IN_W]),
            .valid_out (vchain[k+1]),
            .data_out  (chain[OUT_OFF +: OUT_W])
        );
    end

    assign bus.Z0 = chain[CHAIN_W-1];
    assign bus.VO = vchain[LAT];

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Bench for logic_reduce_pipe: eight configurations share one stimulus
// stream; each has its own scoreboard queue tracking expected result and
// the enabled-cycle count at which it must emerge.
module tb_logic_reduce_pipe;

    localparam int unsigned N = 8;
    localparam int unsigned CW [N] = '{7, 7, 5, 5, 64, 16, 2, 7};
    localparam int unsigned CF [N] = '{4, 4, 4, 4,  2,  8, 2, 2};
    localparam int unsigned CM [N] = '{0, 2, 1, 0,  2,  1, 0, 1};
    localparam int unsigned CI [N] = '{0, 1, 0, 0,  0,  1, 1, 1};
    localparam int unsigned CL [N] = '{2, 2, 2, 2,  6,  2, 1, 3};

    logic        ck = 1'b0;
    logic        cd;
    logic        ce;
    logic        vi;
    logic [63:0] a;
    logic        z_obs  [N];
    logic        vo_obs [N];

    always #5 ck = ~ck;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic_reduce_pipe_if #(.WIDTH(CW[g])) bus ();

        assign bus.CE    = ce;
        assign bus.VI    = vi;
        assign bus.A     = a[CW[g]-1:0];
        assign z_obs[g]  = bus.Z0;
        assign vo_obs[g] = bus.VO;

        logic_reduce_pipe #(
            .WIDTH  (CW[g]),
            .FANIN  (CF[g]),
            .MODE   (CM[g]),
            .INVERT (CI[g])
        ) u_dut (
            .CK  (ck),
            .CD  (cd),
            .bus (bus)
        );
    end

    typedef struct {
        logic        z;
        int unsigned due;
    } sb_t;

    sb_t         sbq [N][$];
    logic        exp_vo  [N];
    logic        exp_z   [N];
    bit          z_known [N];
    int unsigned en_cnt;
    int          n_vec;
    int          n_err;

    function automatic logic ref_reduce(input logic [63:0] v, input int unsigned w,
                                        input int unsigned m, input int unsigned inv);
        logic r;
        r = (m == 0) ? 1'b1 : 1'b0;
        for (int unsigned k = 0; k < w; k++) begin
            if (m == 0)      r = r & v[k];
            else if (m == 1) r = r | v[k];
            else             r = r ^ v[k];
        end
        return r ^ (inv != 0);
    endfunction

    task automatic check(input string tag, input logic obs, input logic expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %b, want %b", tag, obs, expv);
        end
    endtask

    task automatic check_defined(input string tag, input logic obs);
        n_vec++;
        assert (!$isunknown(obs)) else begin
            n_err++;
            $error("FAIL %s: got %b, want a defined 0/1", tag, obs);
        end
    endtask

    // Drive one cycle, advance the reference model, compare every DUT.
    task automatic step(input logic ce_i, input logic vi_i, input logic cd_i,
                        input logic [63:0] a_i);
        sb_t e;
        ce = ce_i;
        vi = vi_i;
        cd = cd_i;
        a  = a_i;
        @(posedge ck);
        #1;
        if (!cd_i && ce_i) en_cnt++;
        for (int unsigned i = 0; i < N; i++) begin
            if (cd_i) begin
                sbq[i].delete();
                exp_vo[i]  = 1'b0;
                exp_z[i]   = 1'b0;
                z_known[i] = 1'b1;
            end else if (ce_i) begin
                if (vi_i) begin
                    e.z   = ref_reduce(a_i, CW[i], CM[i], CI[i]);
                    e.due = en_cnt + CL[i] - 1;
                    sbq[i].push_back(e);
                end
                if (sbq[i].size() != 0 && sbq[i][0].due == en_cnt) begin
                    exp_vo[i]  = 1'b1;
                    exp_z[i]   = sbq[i][0].z;
                    z_known[i] = 1'b1;
                    void'(sbq[i].pop_front());
                end else begin
                    exp_vo[i]  = 1'b0;
                    z_known[i] = 1'b0;
                end
            end
            check($sformatf("d%0d.VO", i), vo_obs[i], exp_vo[i]);
            if (z_known[i]) check($sformatf("d%0d.Z0", i), z_obs[i], exp_z[i]);
            else            check_defined($sformatf("d%0d.Z0def", i), z_obs[i]);
        end
    endtask

    initial begin
        cd = 1'b1;
        ce = 1'b0;
        vi = 1'b0;
        a  = '0;
        en_cnt = 0;
        n_vec  = 0;
        n_err  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            exp_vo[i]  = 1'b0;
            exp_z[i]   = 1'b0;
            z_known[i] = 1'b0;
        end

        // Reset, first with CE low (reset must still act), then with CE high.
        step(1'b0, 1'b0, 1'b1, 64'h0);
        check("rst.VO", vo_obs[0], 1'b0);
        check("rst.Z0", z_obs[0], 1'b0);
        step(1'b1, 1'b0, 1'b1, 64'h0);

        // AND, WIDTH=7: 7F then 7E.
        step(1'b1, 1'b1, 1'b0, 64'h7F);
        step(1'b1, 1'b1, 1'b0, 64'h7E);
        check("and7F.VO", vo_obs[0], 1'b1);
        check("and7F.Z0", z_obs[0], 1'b1);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("and7E.VO", vo_obs[0], 1'b1);
        check("and7E.Z0", z_obs[0], 1'b0);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("and.idle.VO", vo_obs[0], 1'b0);

        // XNOR stream 01, 03, 00.
        step(1'b1, 1'b1, 1'b0, 64'h01);
        step(1'b1, 1'b1, 1'b0, 64'h03);
        check("xnor01.VO", vo_obs[1], 1'b1);
        check("xnor01.Z0", z_obs[1], 1'b0);
        step(1'b1, 1'b1, 1'b0, 64'h00);
        check("xnor03.VO", vo_obs[1], 1'b1);
        check("xnor03.Z0", z_obs[1], 1'b1);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("xnor00.VO", vo_obs[1], 1'b1);
        check("xnor00.Z0", z_obs[1], 1'b1);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("xnor.idle.VO", vo_obs[1], 1'b0);

        // CE stall of three cycles between issue and emergence.
        step(1'b1, 1'b1, 1'b0, 64'h7F);
        check("stall.issue.VO", vo_obs[0], 1'b0);
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0, 64'h0);
            check("stall.hold.VO", vo_obs[0], 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("stall.out.VO", vo_obs[0], 1'b1);
        check("stall.out.Z0", z_obs[0], 1'b1);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("stall.after.VO", vo_obs[0], 1'b0);

        // Reset with CE low while two samples are in flight.
        step(1'b1, 1'b1, 1'b0, 64'h7F);
        step(1'b1, 1'b1, 1'b0, 64'h7F);
        step(1'b0, 1'b0, 1'b1, 64'h0);
        check("midrst.VO", vo_obs[0], 1'b0);
        check("midrst.Z0", z_obs[0], 1'b0);
        repeat (8) begin
            step(1'b1, 1'b0, 1'b0, 64'h0);
            check("midrst.lat6.VO", vo_obs[4], 1'b0);
            check("midrst.lat3.VO", vo_obs[7], 1'b0);
        end

        // Padding of the short chunk, WIDTH=5 FANIN=4.
        step(1'b1, 1'b1, 1'b0, 64'h10);
        step(1'b1, 1'b1, 1'b0, 64'h1F);
        check("pad.or10.VO", vo_obs[2], 1'b1);
        check("pad.or10.Z0", z_obs[2], 1'b1);
        check("pad.and10.Z0", z_obs[3], 1'b0);
        step(1'b1, 1'b1, 1'b0, 64'h0F);
        check("pad.and1F.Z0", z_obs[3], 1'b1);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("pad.and0F.Z0", z_obs[3], 1'b0);

        // Random traffic with random enable, valid and occasional reset.
        for (int unsigned t = 0; t < 1000; t++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 63) == 0), {$urandom, $urandom});
        end

        repeat (8) step(1'b1, 1'b0, 1'b0, 64'h0);
        for (int unsigned i = 0; i < N; i++) begin
            n_vec++;
            assert (sbq[i].size() == 0) else begin
                n_err++;
                $error("FAIL d%0d.drain: %0d results never emerged, want 0",
                       i, sbq[i].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
